matrix_stream_out: RTL and testbench
====================================

# matrix_stream_out

Parallel-to-serial matrix reader for the matrix-multiplier datapath. It takes a one-cycle snapshot of a flattened wide matrix word, the same format the wide operand registers hold. It then streams the matrix out one element per handshake over a valid/ready interface, with row-end and matrix-end markers. It sits between an operand/result register and the narrow consumer that needs elements in order: the MAC array feeder, or result write-back.

## Interface
- ROWS, 4, matrix rows (≥1)
- COLS, 4, matrix columns (≥1)
- EW, 16, element width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  snapshot request
- in  in  [0:ROWS*COLS*EW-1]  flattened matrix, element k=r*COLS+c at bits [k*EW : k*EW+EW-1], bit k*EW is the element MSB
- out_data  out  EW  current element
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_row_end  out  1  current element is the last of its row (or column, transposed)
- out_last  out  1  current element is the final element of the matrix
- busy  out  1  snapshot held and not fully drained
- done  out  1  one-cycle pulse after final transfer
- load_drop  out  1  one-cycle pulse, load ignored

## Operation
- The FSM has two states. IDLE: busy=0, out_valid=0. STREAM: busy=1, out_valid=1.
- IDLE with load=1: capture `in` into the internal snapshot, clear the row/col counters, and go to STREAM.
- STREAM: out_data shows the element at the current counters. A transfer occurs on out_valid & out_ready.
- On each transfer the counters advance in row-major order: c increments, and wraps to 0 with r+1 when c=COLS-1.
- The final transfer is at r=ROWS-1, c=COLS-1. Afterward:
  - If load=1 in the same cycle, re-capture `in`, reset the counters, and stay in STREAM (back-to-back, no bubble).
  - Otherwise go to IDLE.
  - In both cases, done pulses the next cycle.
- STREAM with load=1 and no final transfer: the load is ignored, load_drop pulses the next cycle, and the snapshot is unchanged.
- out_row_end=1 when the in-order index sits at the end of a row; out_last=1 at the final element. Both are qualified by out_valid.
- The snapshot is never modified during STREAM. Changes on `in` have no effect until the next accepted load.
- Counters are sized clog2(ROWS) and clog2(COLS), minimum 1 bit. There is no wrap beyond the final element.
- ROWS=COLS=1: the first transfer is both row_end and last.

## Timing
- Reset (async assert, sync-released by the system):
  - State=IDLE; counters=0; snapshot=0.
  - out_valid=0, out_data=0, out_row_end=0, out_last=0, busy=0, done=0, load_drop=0.
- Load latency: load sampled at edge N gives out_valid=1 with element 0 from edge N (visible in cycle N+1).
- Throughput: one element per cycle with out_ready held high. ROWS*COLS elements take ROWS*COLS cycles.
- With out_valid=1 and out_ready=0: out_data, out_row_end and out_last stay stable. out_valid never drops before its transfer.
- done is asserted the cycle after the final transfer edge. busy falls on the same edge unless a back-to-back load was taken.
- Reset asserted mid-stream: output is abandoned immediately and all outputs return to reset values. No done pulse.
- All outputs are registered. out_ready has no combinational path to out_valid.

## Configuration
- MXS_TRANSPOSE_EN defined: elements stream in column-major order, i.e. the transpose of B for the multiplier.
  - r increments first and wraps to 0 with c+1.
  - out_row_end marks the end of each column, k=(ROWS-1)*COLS+c.
  - The final element, k=ROWS*COLS-1, is unchanged.
- MXS_TRANSPOSE_EN undefined: row-major order as described in Operation. The counter logic for transposition is not present.

## Test plan
- Reset then idle: hold rst_n=0 with load toggling. All outputs are 0; after release, out_valid stays 0 until load.
- Basic stream, 2x2, EW=16, in=0x0001_0002_0003_0004, ready=1:
  - Output sequence 0001,0002,0003,0004.
  - row_end on 2nd and 4th elements; last on 4th.
  - done is 1 cycle after the 4th transfer.
  - Under MXS_TRANSPOSE_EN: 0001,0003,0002,0004.
- Backpressure: out_ready low for 3 cycles on element 1. out_data holds 0002 and out_valid stays 1; the sequence resumes without loss or duplication.
- Load during stream: pulse load with new `in` at element 1. load_drop pulses, and the remaining elements come from the original snapshot.
- Back-to-back: load coincident with the final transfer. done pulses, busy stays 1, and the next cycle shows element 0 of the new matrix.
- Mid-stream reset: assert rst_n=0 after 2 transfers. Outputs clear asynchronously and no done pulse occurs. A new load afterward restarts at element 0.

Source files
------------

// File: rtl/matrix_stream_out.sv
// ---------------------------------------------------------------------------
// matrix_stream_out
//
// Takes a one-cycle snapshot of a flattened ROWS x COLS matrix word and
// streams it out one element per valid/ready handshake. Each element carries
// row-end and matrix-end markers. A load that coincides with the final
// transfer re-captures the input with no bubble. A load at any other time
// during streaming is dropped and reported.
//
// Optional feature macro: MXS_TRANSPOSE_EN
//   Defined   : column-major order (transpose). out_row_end marks column ends.
//   Undefined : row-major order.
//
// Parameters:
//   ROWS, COLS : matrix dimensions (>= 1)
//   EW         : element width in bits
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   load        in   snapshot request
//   in          in   flattened matrix; element k = r*COLS+c occupies
//                    in[k*EW : k*EW+EW-1], and in[k*EW] is its MSB
//   out_data    out  current element
//   out_valid   out  out_data valid
//   out_ready   in   consumer accepts
//   out_row_end out  current element ends a row (a column when transposed)
//   out_last    out  current element is the final one of the matrix
//   busy        out  snapshot held and not yet drained
//   done        out  one-cycle pulse after the final transfer
//   load_drop   out  one-cycle pulse when a load was ignored
// ---------------------------------------------------------------------------
module matrix_stream_out #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int EW   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [0:ROWS*COLS*EW-1]    in,
  output logic [EW-1:0]              out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_row_end,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       load_drop
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [RW-1:0]             r_q, r_d;
  logic [CW-1:0]             c_q, c_d;
  logic [0:ROWS*COLS*EW-1]   snap_q, snap_d;
  logic [EW-1:0]             data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      row_end_q, row_end_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic                      drop_q, drop_d;

  logic xfer_s;
  logic final_s;

  // Element (r, c) of a flattened matrix. Because the vector is ascending,
  // the +: part-select places bit k*EW at the element MSB.
  function automatic logic [EW-1:0] elem(input logic [0:ROWS*COLS*EW-1] m,
                                         input logic [RW-1:0] r,
                                         input logic [CW-1:0] c);
    int k;
    k = int'(r) * COLS + int'(c);
    return m[k*EW +: EW];
  endfunction

  assign xfer_s  = valid_q & out_ready;
  assign final_s = xfer_s & (r_q == R_MAX) & (c_q == C_MAX);

  // Next-state, counter and snapshot logic, plus the registered-output values.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          snap_d  = in;
          r_d     = '0;
          c_d     = '0;
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (final_s) begin
          done_d = 1'b1;
          r_d    = '0;
          c_d    = '0;
          if (load) begin
            // Back-to-back: the new matrix follows with no idle cycle.
            snap_d  = in;
            state_d = S_STREAM;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          drop_d = load;
          if (xfer_s) begin
`ifdef MXS_TRANSPOSE_EN
            if (r_q == R_MAX) begin
              r_d = '0;
              c_d = c_q + 1'b1;
            end else begin
              r_d = r_q + 1'b1;
            end
`else
            if (c_q == C_MAX) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
`endif
          end else begin
            r_d = r_q;
            c_d = c_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        r_d     = '0;
        c_d     = '0;
      end
    endcase

    // Outputs are computed from the next state so they can be registered
    // and still line up with the counters they describe.
    valid_d = (state_d == S_STREAM);
    if (valid_d) begin
      data_d = elem(snap_d, r_d, c_d);
`ifdef MXS_TRANSPOSE_EN
      row_end_d = (r_d == R_MAX);
`else
      row_end_d = (c_d == C_MAX);
`endif
      last_d = (r_d == R_MAX) & (c_d == C_MAX);
    end else begin
      data_d    = '0;
      row_end_d = 1'b0;
      last_d    = 1'b0;
    end
  end

  // State, counters, snapshot and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      snap_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      row_end_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      snap_q    <= snap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      row_end_q <= row_end_d;
      last_q    <= last_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_row_end = row_end_q;
  assign out_last    = last_q;
  assign busy        = valid_q;
  assign done        = done_q;
  assign load_drop   = drop_q;

endmodule

// File: tb/tb_matrix_stream_out.sv
// ---------------------------------------------------------------------------
// Directed bench for matrix_stream_out with a 2x2 matrix of 16-bit elements.
// Expected values are hand-computed. The expected element order follows
// MXS_TRANSPOSE_EN so the bench covers either build.
// ---------------------------------------------------------------------------
module tb_matrix_stream_out;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int EW   = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    load;
  logic [0:ROWS*COLS*EW-1] in;
  logic [EW-1:0]           out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_row_end;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic                    load_drop;

  int errors = 0;
  int checks = 0;

  logic [63:0] mat_a;
  logic [63:0] mat_b;
  logic [15:0] exp_a [4];
  logic [15:0] exp_b [4];
  logic        exp_re [4];

  matrix_stream_out #(.ROWS(ROWS), .COLS(COLS), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_end(out_row_end), .out_last(out_last), .busy(busy),
    .done(done), .load_drop(load_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_elem(input string tag, input logic [15:0] d, input logic re, input logic lst);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " data"}, 32'(out_data), 32'(d));
    check({tag, " row_end"}, 32'(out_row_end), 32'(re));
    check({tag, " last"}, 32'(out_last), 32'(lst));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({out_valid, out_data, out_row_end, out_last, busy, done, load_drop});
  endfunction

  initial begin
    mat_a = 64'h0001_0002_0003_0004;
    mat_b = 64'h00AA_00BB_00CC_00DD;
`ifdef MXS_TRANSPOSE_EN
    exp_a = '{16'h0001, 16'h0003, 16'h0002, 16'h0004};
    exp_b = '{16'h00AA, 16'h00CC, 16'h00BB, 16'h00DD};
`else
    exp_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_b = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD};
`endif
    exp_re = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset with load toggling
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b1; in = mat_a;
    for (int i = 0; i < 4; i++) begin
      load = ~load;
      step();
      check("reset outputs", all_outs(), 32'd0);
    end
    load = 1'b0;
    rst_n = 1'b1;
    step(); step();
    check("idle after reset", all_outs(), 32'd0);

    // Basic stream
    load = 1'b1; in = mat_a;
    step();
    load = 1'b0; in = mat_b;
    for (int i = 0; i < 4; i++) begin
      check_elem($sformatf("basic e%0d", i), exp_a[i], exp_re[i], i == 3);
      check("basic busy", 32'(busy), 32'd1);
      check("basic no done", 32'(done), 32'd0);
      step();
    end
    check("basic done", 32'(done), 32'd1);
    check("basic idle valid", 32'(out_valid), 32'd0);
    check("basic idle busy", 32'(busy), 32'd0);
    step();
    check("basic done pulse", 32'(done), 32'd0);

    // Backpressure on element 1
    load = 1'b1; in = mat_a;
    step();
    load = 1'b0;
    check_elem("bp e0", exp_a[0], 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_elem("bp hold", exp_a[1], 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check_elem("bp e2", exp_a[2], 1'b0, 1'b0);
    step();
    check_elem("bp e3", exp_a[3], 1'b1, 1'b1);
    step();
    check("bp done", 32'(done), 32'd1);

    // Load during stream is dropped
    load = 1'b1; in = mat_a;
    step();
    load = 1'b0;
    step();
    check_elem("drop e1", exp_a[1], 1'b1, 1'b0);
    load = 1'b1; in = mat_b;
    step();
    load = 1'b0;
    check("drop pulse", 32'(load_drop), 32'd1);
    check_elem("drop e2", exp_a[2], 1'b0, 1'b0);
    step();
    check("drop pulse end", 32'(load_drop), 32'd0);
    check_elem("drop e3", exp_a[3], 1'b1, 1'b1);
    step();
    check("drop done", 32'(done), 32'd1);
    check("drop idle", 32'(out_valid), 32'd0);

    // Back-to-back load on the final transfer
    load = 1'b1; in = mat_a;
    step();
    load = 1'b0;
    step(); step(); step();
    check_elem("b2b a3", exp_a[3], 1'b1, 1'b1);
    load = 1'b1; in = mat_b;
    step();
    load = 1'b0;
    check("b2b done", 32'(done), 32'd1);
    check("b2b busy", 32'(busy), 32'd1);
    check_elem("b2b b0", exp_b[0], 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      check_elem($sformatf("b2b b%0d", i), exp_b[i], exp_re[i], i == 3);
    end
    step();
    check("b2b end done", 32'(done), 32'd1);
    check("b2b end idle", 32'(busy), 32'd0);

    // Mid-stream reset after two transfers
    load = 1'b1; in = mat_a;
    step();
    load = 1'b0;
    step(); step();
    check_elem("mrst e2", exp_a[2], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst async clear", all_outs(), 32'd0);
    step(); step();
    check("mrst held", all_outs(), 32'd0);
    rst_n = 1'b1;
    step();
    check("mrst no done", all_outs(), 32'd0);
    load = 1'b1; in = mat_b;
    step();
    load = 1'b0;
    check_elem("mrst restart", exp_b[0], 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
